// File: rtl/seg_scan.sv
// seg_scan: 4-digit common-anode display scanner with frame-synchronous word latching.
// Optional blink gating is compiled in with `define SEG_SCAN_BLINK_EN.
module seg_scan #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seg_word,
  input  logic        load,
  input  logic        blink,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        load_ack,
  output logic        frame_start
);

  localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

  logic [CW-1:0] slot_cnt;
  logic [1:0]    digit;
  logic [31:0]   shadow;
  logic [31:0]   active;
  logic          pending;
  logic          boundary;
  logic          capture;
  logic          lit;

  assign boundary = (slot_cnt == SLOT_LAST) && (digit == 2'd0);
  // A load in the boundary cycle itself is taken directly, bypassing shadow.
  assign capture  = boundary && (pending || load);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt    <= '0;
      digit       <= 2'd3;
      shadow      <= 32'hFFFF_FFFF;
      active      <= 32'hFFFF_FFFF;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      an          <= 4'b1111;
      seg         <= 8'hFF;
    end else begin
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        digit    <= digit - 2'd1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      if (load) shadow <= seg_word;

      if (capture) begin
        active  <= load ? seg_word : shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      load_ack    <= capture;
      frame_start <= (digit == 2'd3) && (slot_cnt == '0);

      // Registered from the current counter state, so outputs trail it by one cycle.
      if ((slot_cnt < BLANK_LIM) || !lit) begin
        an  <= 4'b1111;
        seg <= 8'hFF;
      end else begin
        an  <= ~(4'b0001 << digit);
        seg <= active[8*digit +: 8];
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] FRAME_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] frame_cnt;
  logic          phase;

  // phase flips at frame boundaries only, so off periods cover whole frames.
  always_ff @(posedge clk) begin
    if (rst || !blink) begin
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else if (boundary) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign lit = phase;
`else
  logic unused_blink;
  assign unused_blink = blink;
  assign lit          = 1'b1;
`endif

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed scoreboard bench for seg_scan; expected frames are queued when
// loads are driven and popped as each displayed frame is sampled.
module tb_seg_scan;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = 4 * DC;

  typedef struct packed {
    logic        lit;
    logic [31:0] word;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seg_word;
  logic        load;
  logic        blink;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        load_ack;
  logic        frame_start;

  frame_t exp_q[$];
  int     n_asserts = 0;
  int     n_fails   = 0;

  always #5 clk = ~clk;

  seg_scan #(
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seg_word(seg_word),
    .load(load),
    .blink(blink),
    .an(an),
    .seg(seg),
    .load_ack(load_ack),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic lit, input logic [31:0] word);
    frame_t f;
    f.lit  = lit;
    f.word = word;
    exp_q.push_back(f);
  endtask

  // Advance n sampling points; load is a one-cycle strobe so it drops after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] word, input bit expect_shown);
    seg_word = word;
    load     = 1'b1;
    if (expect_shown) push_frame(1'b1, word);
  endtask

  // Advance until frame_start is sampled high; report cycles taken and ack activity.
  task automatic wait_frame(output int steps, output int acks, output logic ack_prev);
    logic last;
    bit   found;
    steps    = 0;
    acks     = 0;
    ack_prev = 1'b0;
    last     = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      load = 1'b0;
      steps++;
      if (load_ack) acks++;
      if (frame_start) begin
        ack_prev = last;
        found    = 1'b1;
        break;
      end
      last = load_ack;
    end
    if (!found) chk("frame_start_timeout", 32'd0, 32'd1);
  endtask

  // Sample one whole frame starting at the current frame_start sample.
  task automatic check_output(input string tag);
    frame_t     f;
    logic [3:0] ea;
    logic [7:0] es;
    int         d;
    int         s;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    f = exp_q.pop_front();
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) begin
        @(negedge clk);
        load = 1'b0;
      end
      d = 3 - k / DC;
      s = k % DC;
      if (!f.lit || s < BC) begin
        ea = 4'b1111;
        es = 8'hFF;
      end else begin
        ea    = 4'b1111;
        ea[d] = 1'b0;
        es    = f.word[8*d +: 8];
      end
      chk($sformatf("%s_k%0d_an", tag, k), 32'(an), 32'(ea));
      chk($sformatf("%s_k%0d_seg", tag, k), 32'(seg), 32'(es));
      chk($sformatf("%s_k%0d_ack", tag, k), 32'(load_ack), 32'd0);
      chk($sformatf("%s_k%0d_fs", tag, k), 32'(frame_start), (k == 0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int     steps;
    int     acks;
    logic   ack_prev;
    logic   blink_lit[6];

    rst      = 1'b1;
    load     = 1'b0;
    blink    = 1'b0;
    seg_word = 32'h0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset%0d_an", i), 32'(an), 32'hF);
      chk($sformatf("reset%0d_seg", i), 32'(seg), 32'hFF);
      chk($sformatf("reset%0d_ack", i), 32'(load_ack), 32'd0);
      chk($sformatf("reset%0d_fs", i), 32'(frame_start), 32'd0);
    end
    rst = 1'b0;
    $display("[TB] reset released");

    wait_frame(steps, acks, ack_prev);
    chk("reset_fs_latency", 32'(steps), 32'd1);
    chk("reset_acks", 32'(acks), 32'd0);
    push_frame(1'b1, 32'hFFFF_FFFF);
    check_output("reset_frame");

    $display("[TB] normal load");
    step(10);
    apply_stimulus(32'hFF11_D585, 1'b1);
    wait_frame(steps, acks, ack_prev);
    chk("normal_ack_count", 32'(acks), 32'd1);
    chk("normal_ack_before_fs", 32'(ack_prev), 32'd1);
    check_output("normal");

    $display("[TB] last-wins load");
    step(5);
    apply_stimulus(32'h1234_5678, 1'b0);
    step(3);
    apply_stimulus(32'h9ABC_DEF0, 1'b1);
    wait_frame(steps, acks, ack_prev);
    chk("lastwins_ack_count", 32'(acks), 32'd1);
    chk("lastwins_ack_before_fs", 32'(ack_prev), 32'd1);
    check_output("lastwins");

    $display("[TB] boundary-cycle load");
    step(FRAME - 1);
    apply_stimulus(32'h0000_0000, 1'b1);
    wait_frame(steps, acks, ack_prev);
    chk("boundary_steps", 32'(steps), 32'd2);
    chk("boundary_ack_count", 32'(acks), 32'd1);
    chk("boundary_ack_before_fs", 32'(ack_prev), 32'd1);
    check_output("boundary");

    $display("[TB] mid-frame reset");
    step(5);
    apply_stimulus(32'h0000_0000, 1'b0);
    step(3);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    wait_frame(steps, acks, ack_prev);
    chk("midreset_fs_latency", 32'(steps), 32'd1);
    chk("midreset_acks", 32'(acks), 32'd0);
    push_frame(1'b1, 32'hFFFF_FFFF);
    check_output("midreset_f0");
    wait_frame(steps, acks, ack_prev);
    chk("midreset_frame_len", 32'(steps), 32'd1);
    chk("midreset_late_ack", 32'(acks), 32'd0);
    push_frame(1'b1, 32'hFFFF_FFFF);
    check_output("midreset_f1");

    $display("[TB] blink");
`ifdef SEG_SCAN_BLINK_EN
    blink_lit = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    blink_lit = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    wait_frame(steps, acks, ack_prev);
    chk("blink_pre_frame_len", 32'(steps), 32'd1);
    blink = 1'b1;
    for (int i = 0; i < 6; i++) push_frame(blink_lit[i], 32'hFFFF_FFFF);
    check_output("blink_f0");
    for (int i = 1; i < 6; i++) begin
      wait_frame(steps, acks, ack_prev);
      chk($sformatf("blink_f%0d_len", i), 32'(steps), 32'd1);
      check_output($sformatf("blink_f%0d", i));
    end
    blink = 1'b0;
    push_frame(1'b1, 32'hFFFF_FFFF);
    wait_frame(steps, acks, ack_prev);
    chk("unblink_frame_len", 32'(steps), 32'd1);
    check_output("unblink");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
